vga_timing_monitor: RTL

- Receive-side checker for the game's VGA output: consumes hsync/vsync/red/green/blue as produced by the game core and recovers line and frame timing.
- Locks to the expected mode, reports per-frame lit-pixel totals and counts timing faults.
- Sits beside solo_squash_caravel in the user project; results are exposed on logic-analyser outputs for on-chip self-test of the video path.

---
 rtl/vga_timing_monitor.sv | 120 ++++++++++++
 1 files changed

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers VGA line/frame timing, locks to the mode, reports per-frame lit totals and timing faults.
//   Ports: wb_clk_i clock; ext_reset_n sync active-low reset; hsync/vsync/red/green/blue video in;
//   locked, frame_done, frame_count[15:0], frame_lit[19:0], last_line_len[10:0], err_count[7:0],
//   state[1:0] (0 SEARCH, 1 ACQUIRE, 2 LOCKED), frame_crc[15:0].
//   Optional macro VGA_MON_CRC_EN adds a per-frame CRC-16-CCITT of the rgb stream; otherwise frame_crc is 0.
module vga_timing_monitor #(
  parameter int H_TOTAL = 800,
  parameter int H_SYNC_W = 96,
  parameter int V_TOTAL = 525,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        wb_clk_i,
  input  logic        ext_reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        red,
  input  logic        green,
  input  logic        blue,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [19:0] frame_lit,
  output logic [10:0] last_line_len,
  output logic [7:0]  err_count,
  output logic [1:0]  state,
  output logic [15:0] frame_crc
);
  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;
  localparam logic POL = (SYNC_ACTIVE_LOW != 0);
  state_t      r_state, w_next;
  logic        r_hs_q, r_hs_p, r_vs_q, r_vs_p, r_h_valid;
  logic [2:0]  r_rgb_q;
  logic [10:0] r_h_cnt, w_line_len, w_lines;
  logic [9:0]  r_v_cnt;
  logic [7:0]  r_hs_w;
  logic [19:0] r_lit_acc;
  logic        w_hs_lead, w_hs_trail, w_vs_lead, w_lit, w_line_err, w_frame_err, w_err, w_done, w_err_inc;
  // sync registers hold the normalised (1 = asserted) level, so reset never fakes an edge
  assign w_hs_lead = r_hs_q & ~r_hs_p;
  assign w_hs_trail = ~r_hs_q & r_hs_p;
  assign w_vs_lead = r_vs_q & ~r_vs_p;
  assign w_lit = |r_rgb_q;
  assign w_line_len = (r_h_cnt == 11'h7FF) ? r_h_cnt : r_h_cnt + 11'd1;
  // an hs_lead coincident with vs_lead belongs to the frame that is ending
  assign w_lines = {1'b0, r_v_cnt} + {10'd0, w_hs_lead};
  assign w_line_err = (w_hs_lead & (w_line_len != 11'(H_TOTAL))) |
                      (w_hs_trail & (r_hs_w != 8'(H_SYNC_W))) |
                      (w_lines > 11'(V_TOTAL));
  assign w_frame_err = w_vs_lead & (w_lines != 11'(V_TOTAL));
  assign w_err = w_line_err | w_frame_err;
  assign state = r_state;
  always_comb begin
    w_next = (r_state == SEARCH) ? ((w_vs_lead && (r_h_valid || w_hs_lead)) ? ACQUIRE : SEARCH) :
             (r_state == ACQUIRE) ? (w_line_err ? SEARCH : (w_vs_lead && !w_frame_err) ? LOCKED : ACQUIRE) :
             (r_state == LOCKED) ? (w_err ? SEARCH : LOCKED) : SEARCH;
    w_done = (r_state == LOCKED) && w_vs_lead && !w_err;
    w_err_inc = (r_state == LOCKED) && w_err;
  end
  always_ff @(posedge wb_clk_i) begin
    if (!ext_reset_n) begin
      r_state <= SEARCH;
      r_hs_q <= 1'b0;
      r_hs_p <= 1'b0;
      r_vs_q <= 1'b0;
      r_vs_p <= 1'b0;
      r_rgb_q <= '0;
      r_h_valid <= 1'b0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hs_w <= '0;
      r_lit_acc <= '0;
      locked <= 1'b0;
      frame_done <= 1'b0;
      frame_count <= '0;
      frame_lit <= '0;
      last_line_len <= '0;
      err_count <= '0;
    end else begin
      r_state <= w_next;
      r_hs_q <= hsync ^ POL;
      r_hs_p <= r_hs_q;
      r_vs_q <= vsync ^ POL;
      r_vs_p <= r_vs_q;
      r_rgb_q <= {red, green, blue};
      r_h_valid <= r_h_valid | w_hs_lead;
      r_h_cnt <= w_hs_lead ? 11'd0 : (r_h_cnt != 11'h7FF) ? r_h_cnt + 11'd1 : r_h_cnt;
      r_v_cnt <= w_vs_lead ? 10'd0 : (w_hs_lead && r_v_cnt != 10'h3FF) ? r_v_cnt + 10'd1 : r_v_cnt;
      r_hs_w <= w_hs_trail ? 8'd0 : (r_hs_q && r_hs_w != 8'hFF) ? r_hs_w + 8'd1 : r_hs_w;
      // the vs_lead cycle itself is the first cycle of the new frame
      r_lit_acc <= w_vs_lead ? {19'd0, w_lit} : (w_lit && r_lit_acc != 20'hFFFFF) ? r_lit_acc + 20'd1 : r_lit_acc;
      locked <= (w_next == LOCKED);
      frame_done <= w_done;
      frame_count <= frame_count + {15'd0, w_done};
      frame_lit <= w_done ? r_lit_acc : frame_lit;
      last_line_len <= w_hs_lead ? w_line_len : last_line_len;
      err_count <= (w_err_inc && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end
  end
`ifdef VGA_MON_CRC_EN
  logic [15:0] r_crc;
  // CRC-16-CCITT, MSB first, bits taken red then green then blue
  function automatic logic [15:0] crc3(input logic [15:0] c, input logic [2:0] d);
    logic [15:0] x;
    x = c;
    for (int k = 2; k >= 0; k--) x = {x[14:0], 1'b0} ^ ((x[15] ^ d[k]) ? 16'h1021 : 16'h0000);
    return x;
  endfunction
  always_ff @(posedge wb_clk_i) begin
    if (!ext_reset_n) begin
      r_crc <= '0;
      frame_crc <= '0;
    end else begin
      r_crc <= crc3(w_vs_lead ? 16'hFFFF : r_crc, r_rgb_q);
      frame_crc <= w_done ? r_crc : frame_crc;
    end
  end
`else
  assign frame_crc = 16'd0;
`endif
endmodule
